// File: rtl/rx_frame_assembler_if.sv
`default_nettype none
// ============================================================================
// Module      : rx_frame_assembler_if
// Description : Byte-stream input and frame handshake bundle for the assembler.
// Revision    : 1.0 - initial release
// ============================================================================
interface rx_frame_assembler_if #(
   parameter int NUM_OPERANDS  = 2,
   parameter int OPERAND_BYTES = 2
);
   localparam int c_w = 8 * OPERAND_BYTES;

   logic                        rx_ready;
   logic [7:0]                  rx_data;
   logic                        frame_ready;
   logic [NUM_OPERANDS*c_w-1:0] operands;
   logic [7:0]                  cmd;
   logic                        frame_valid;
   logic                        busy;
   logic                        timeout_err;
   logic                        overrun_err;

   // master: the assembler itself; slave: the UART receiver / frame consumer side
   modport master (
      input  rx_ready, rx_data, frame_ready,
      output operands, cmd, frame_valid, busy, timeout_err, overrun_err
   );

   modport slave (
      output rx_ready, rx_data, frame_ready,
      input  operands, cmd, frame_valid, busy, timeout_err, overrun_err
   );
endinterface
`default_nettype wire

// File: rtl/rx_frame_assembler.sv
`default_nettype none
// ============================================================================
// Module      : rx_frame_assembler
// Description : Assembles operand bytes plus a command byte into one frame.
// Revision    : 1.0 - initial release
// ============================================================================
module rx_frame_assembler #(
   parameter int NUM_OPERANDS   = 2,
   parameter int OPERAND_BYTES  = 2,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  wire logic             clk,
   input  wire logic             reset,
   rx_frame_assembler_if.master  bus
);
   localparam int c_w         = 8 * OPERAND_BYTES;
   localparam int c_op_bits   = NUM_OPERANDS * c_w;
   localparam int c_frame_len = NUM_OPERANDS * OPERAND_BYTES + 1;
   localparam int c_b_w       = $clog2(c_frame_len);
   localparam int c_idle_w    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam bit c_timeout_en = (TIMEOUT_CYCLES != 0);
   localparam logic [c_b_w-1:0]    c_last    = c_b_w'(c_frame_len - 1);
   localparam logic [c_idle_w-1:0] c_timeout = c_idle_w'(TIMEOUT_CYCLES);

   typedef enum logic [0:0] {
      S_COLLECT = 1'b0,
      S_HOLD    = 1'b1
   } state_t;

   state_t               state_q,    state_d;
   logic [c_b_w-1:0]     b_q,        b_d;
   logic [c_idle_w-1:0]  idle_q,     idle_d;
   logic [c_op_bits-1:0] operands_q, operands_d;
   logic [7:0]           cmd_q,      cmd_d;
   logic                 timeout_q,  timeout_d;
   logic                 overrun_q,  overrun_d;
   logic [c_idle_w-1:0]  w_idle_inc;

   assign w_idle_inc = idle_q + 1'b1;

   always_comb begin
      state_d    = state_q;
      b_d        = b_q;
      idle_d     = idle_q;
      operands_d = operands_q;
      cmd_d      = cmd_q;
      timeout_d  = 1'b0;
      overrun_d  = 1'b0;

      unique case (state_q)
         S_COLLECT: begin
            if (bus.rx_ready) begin
               idle_d = '0;
               if (b_q == c_last) begin
                  cmd_d   = bus.rx_data;
                  state_d = S_HOLD;
               end else begin
                  // Byte b lands at bit b*8: operand b/OPERAND_BYTES, lane b%OPERAND_BYTES
                  for (int i = 0; i < c_frame_len - 1; i++) begin
                     if (b_q == c_b_w'(i)) begin
                        operands_d[i*8 +: 8] = bus.rx_data;
                     end
                  end
                  b_d = b_q + 1'b1;
               end
            end else if (c_timeout_en && (b_q != '0)) begin
               if (w_idle_inc == c_timeout) begin
                  b_d       = '0;
                  idle_d    = '0;
                  timeout_d = 1'b1;
               end else begin
                  idle_d = w_idle_inc;
               end
            end
         end
         S_HOLD: begin
            idle_d = '0;
            if (bus.frame_ready) begin
               state_d = S_COLLECT;
               b_d     = '0;
               // A byte arriving with the accept starts the next frame
               if (bus.rx_ready) begin
                  operands_d[7:0] = bus.rx_data;
                  b_d             = c_b_w'(1);
               end
            end else if (bus.rx_ready) begin
               overrun_d = 1'b1;
            end
         end
         default: state_d = S_COLLECT;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_COLLECT;
         b_q        <= '0;
         idle_q     <= '0;
         operands_q <= '0;
         cmd_q      <= '0;
         timeout_q  <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         b_q        <= b_d;
         idle_q     <= idle_d;
         operands_q <= operands_d;
         cmd_q      <= cmd_d;
         timeout_q  <= timeout_d;
         overrun_q  <= overrun_d;
      end
   end

   assign bus.operands    = operands_q;
   assign bus.cmd         = cmd_q;
   assign bus.frame_valid = (state_q == S_HOLD);
   assign bus.busy        = (state_q == S_HOLD) || (b_q != '0);
   assign bus.timeout_err = timeout_q;
   assign bus.overrun_err = overrun_q;
endmodule
`default_nettype wire
